// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit line encoder.
`timescale 1ns/1ps
package usb_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      EOP_SE0,
      EOP_J
   } state_t;

   localparam logic [7:0] SYNC_PATTERN = 8'h80;

   // Line states packed as {d_plus, d_minus}.
   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-time counter: runs 0..CLKS_PER_BIT-1 while enabled, bit_tick marks the wrap cycle.
`timescale 1ns/1ps
module usb_bit_timer #(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clear,
   input  logic run,
   output logic bit_tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   assign bit_tick = run && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= bit_tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/usb_tx_line_encoder.sv
// USB transmit line encoder: SYNC, bit stuffing, NRZI and EOP generation from a byte stream.
`timescale 1ns/1ps
module usb_tx_line_encoder
   import usb_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 8,
   parameter int STUFF_LEN    = 6,
   parameter int EOP_SE0_BITS = 2
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   input  logic       tx_data_valid,
   output logic       tx_data_ready,
   output logic       d_plus,
   output logic       d_minus,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int OW = $clog2(STUFF_LEN + 1);
   localparam int SW = $clog2(EOP_SE0_BITS + 1);
   localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LEN);
   localparam logic [SW-1:0] SE0_LAST  = SW'(EOP_SE0_BITS);

   state_t        state, nxt_state;
   logic [2:0]    idx, nxt_idx;
   logic          pend, nxt_pend;
   logic [7:0]    shift, nxt_shift;
   logic          cur_last, nxt_cur_last;
   logic [OW-1:0] ones, nxt_ones;
   logic [SW-1:0] se0_cnt, nxt_se0;
   logic          lvl_j, nxt_lvl_j;
   logic [1:0]    line_q, nxt_line;
   logic [7:0]    hold_data;
   logic          hold_last;
   logic          hold_full, nxt_hold_full;
   logic          last_seen, nxt_last_seen;
   logic          err_q, nxt_err;
   logic          done_q, nxt_done;
   logic          nxt_ready;
   logic          accept, bit_tick;
   logic          launch, lbit, go_eop, eop_err;
   logic          step, step_pend, step_last;

   usb_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .n_rst   (n_rst),
      .clear   ((state == IDLE) && tx_start),
      .run     (state != IDLE),
      .bit_tick(bit_tick)
   );

   assign accept = tx_data_valid && tx_data_ready;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= nxt_state;
      end
   end

   always_comb begin
      nxt_state     = state;
      nxt_idx       = idx;
      nxt_pend      = pend;
      nxt_shift     = shift;
      nxt_cur_last  = cur_last;
      nxt_ones      = ones;
      nxt_se0       = se0_cnt;
      nxt_lvl_j     = lvl_j;
      nxt_line      = line_q;
      nxt_hold_full = hold_full;
      nxt_last_seen = last_seen;
      nxt_err       = 1'b0;
      nxt_done      = 1'b0;
      launch        = 1'b0;
      lbit          = 1'b0;
      go_eop        = 1'b0;
      eop_err       = 1'b0;
      step          = 1'b0;
      step_pend     = pend;
      step_last     = cur_last;

      if (accept) begin
         nxt_hold_full = 1'b1;
         if (tx_last) nxt_last_seen = 1'b1;
      end

      case (state)
         IDLE: begin
            if (tx_start) begin
               nxt_state     = SYNC;
               nxt_idx       = '0;
               nxt_pend      = 1'b0;
               nxt_ones      = '0;
               nxt_last_seen = 1'b0;
               launch        = 1'b1;
               lbit          = SYNC_PATTERN[0];
            end
         end
         SYNC: begin
            if (bit_tick) begin
               if (idx != 3'd7) begin
                  nxt_idx = idx + 3'd1;
                  launch  = 1'b1;
                  lbit    = SYNC_PATTERN[nxt_idx];
               end else if (!hold_full) begin
                  go_eop  = 1'b1;
                  eop_err = 1'b1;
               end else begin
                  // Enter DATA with an empty shifter so the common byte-boundary
                  // path handles both a pending stuff bit and the first load.
                  nxt_state    = DATA;
                  nxt_cur_last = 1'b0;
                  step         = 1'b1;
                  step_pend    = 1'b0;
                  step_last    = 1'b0;
               end
            end
         end
         DATA: begin
            if (bit_tick) step = 1'b1;
         end
         EOP_SE0: begin
            if (bit_tick) begin
               if (se0_cnt == SE0_LAST) begin
                  nxt_state = EOP_J;
                  nxt_line  = LINE_J;
                  nxt_lvl_j = 1'b1;
               end else begin
                  nxt_se0 = se0_cnt + 1'b1;
               end
            end
         end
         EOP_J: begin
            if (bit_tick) begin
               nxt_state     = IDLE;
               nxt_done      = 1'b1;
               nxt_hold_full = 1'b0;
               nxt_last_seen = 1'b0;
            end
         end
         default: nxt_state = IDLE;
      endcase

      // Stuff check precedes the byte boundary, so a due stuff bit goes out before EOP.
      if (step) begin
         if (ones == STUFF_MAX) begin
            launch = 1'b1;
            lbit   = 1'b0;
         end else if (step_pend) begin
            launch  = 1'b1;
            lbit    = shift[idx];
            nxt_idx = idx + 3'd1;
            if (idx == 3'd7) nxt_pend = 1'b0;
         end else if (step_last) begin
            go_eop = 1'b1;
         end else if (hold_full) begin
            nxt_shift     = hold_data;
            nxt_cur_last  = hold_last;
            nxt_hold_full = 1'b0;
            nxt_pend      = 1'b1;
            nxt_idx       = 3'd1;
            launch        = 1'b1;
            lbit          = hold_data[0];
         end else begin
            go_eop  = 1'b1;
            eop_err = 1'b1;
         end
      end

      if (go_eop) begin
         nxt_state = EOP_SE0;
         nxt_se0   = SW'(1);
         nxt_line  = LINE_SE0;
         nxt_err   = eop_err;
      end

      if (launch) begin
         if (lbit) begin
            nxt_ones = ones + 1'b1;
         end else begin
            nxt_lvl_j = ~lvl_j;
            nxt_ones  = '0;
         end
         nxt_line = nxt_lvl_j ? LINE_J : LINE_K;
      end

      nxt_ready = ((nxt_state == SYNC) || (nxt_state == DATA)) &&
                  !nxt_hold_full && !nxt_last_seen;
   end

   // Lines and status go through one more register so every bit, busy and done
   // share the same alignment with the bit timer.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         idx           <= '0;
         pend          <= 1'b0;
         shift         <= '0;
         cur_last      <= 1'b0;
         ones          <= '0;
         se0_cnt       <= '0;
         lvl_j         <= 1'b1;
         line_q        <= LINE_J;
         hold_data     <= '0;
         hold_last     <= 1'b0;
         hold_full     <= 1'b0;
         last_seen     <= 1'b0;
         err_q         <= 1'b0;
         done_q        <= 1'b0;
         tx_data_ready <= 1'b0;
         d_plus        <= 1'b1;
         d_minus       <= 1'b0;
         tx_busy       <= 1'b0;
         tx_done       <= 1'b0;
         tx_error      <= 1'b0;
      end else begin
         idx           <= nxt_idx;
         pend          <= nxt_pend;
         shift         <= nxt_shift;
         cur_last      <= nxt_cur_last;
         ones          <= nxt_ones;
         se0_cnt       <= nxt_se0;
         lvl_j         <= nxt_lvl_j;
         line_q        <= nxt_line;
         hold_full     <= nxt_hold_full;
         last_seen     <= nxt_last_seen;
         err_q         <= nxt_err;
         done_q        <= nxt_done;
         tx_data_ready <= nxt_ready;
         if (accept) begin
            hold_data <= tx_data;
            hold_last <= tx_last;
         end
         d_plus   <= line_q[1];
         d_minus  <= line_q[0];
         tx_busy  <= (state != IDLE);
         tx_done  <= done_q;
         tx_error <= err_q;
      end
   end

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Directed scoreboard bench for usb_tx_line_encoder at two parameter sets.
`timescale 1ns/1ps
module tb_usb_tx_line_encoder;

   logic       clk;
   logic       n_rst;
   logic       start;
   logic       sel;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       valid;

   logic r1, dp1, dm1, b1, dn1, e1;
   logic r2, dp2, dm2, b2, dn2, e2;
   logic r_s, dp_s, dm_s, b_s, dn_s, e_s;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt;
   int err_cnt;
   logic last_acc;

   logic [7:0] pkt [0:3];
   logic [1:0] exp_q [$];

   usb_tx_line_encoder #(
      .CLKS_PER_BIT(4),
      .STUFF_LEN   (6),
      .EOP_SE0_BITS(2)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .tx_start     (start && !sel),
      .tx_data      (tx_data),
      .tx_last      (tx_last),
      .tx_data_valid(valid),
      .tx_data_ready(r1),
      .d_plus       (dp1),
      .d_minus      (dm1),
      .tx_busy      (b1),
      .tx_done      (dn1),
      .tx_error     (e1)
   );

   usb_tx_line_encoder #(
      .CLKS_PER_BIT(2),
      .STUFF_LEN   (3),
      .EOP_SE0_BITS(3)
   ) dut_sweep (
      .clk          (clk),
      .n_rst        (n_rst),
      .tx_start     (start && sel),
      .tx_data      (tx_data),
      .tx_last      (tx_last),
      .tx_data_valid(valid),
      .tx_data_ready(r2),
      .d_plus       (dp2),
      .d_minus      (dm2),
      .tx_busy      (b2),
      .tx_done      (dn2),
      .tx_error     (e2)
   );

   assign r_s  = sel ? r2  : r1;
   assign dp_s = sel ? dp2 : dp1;
   assign dm_s = sel ? dm2 : dm1;
   assign b_s  = sel ? b2  : b1;
   assign dn_s = sel ? dn2 : dn1;
   assign e_s  = sel ? e2  : e1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference line sequence: SYNC, stuffed/NRZI data, EOP; one entry per bit time.
   task automatic build_exp(input int n, input int stf, input int se0n);
      logic [1:0] lvl = 2'b10;
      int ones = 0;
      logic [7:0] sync = 8'h80;
      logic [7:0] byt;
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         if (!sync[i]) begin lvl = ~lvl; ones = 0; end
         else ones++;
         exp_q.push_back(lvl);
      end
      for (int k = 0; k < n; k++) begin
         byt = pkt[k];
         for (int i = 0; i < 8; i++) begin
            if (ones == stf) begin lvl = ~lvl; ones = 0; exp_q.push_back(lvl); end
            if (!byt[i]) begin lvl = ~lvl; ones = 0; end
            else ones++;
            exp_q.push_back(lvl);
         end
      end
      if (n > 0 && ones == stf) begin lvl = ~lvl; exp_q.push_back(lvl); end
      repeat (se0n) exp_q.push_back(2'b00);
      exp_q.push_back(2'b10);
   endtask

   task automatic run_pkt(input int navail, input bit last_flag, input int exp_err, input bit chk_acc);
      int cpb  = sel ? 2 : 4;
      int stf  = sel ? 3 : 6;
      int se0n = sel ? 3 : 2;
      int t0;
      build_exp(navail, stf, se0n);
      done_cnt = 0;
      err_cnt  = 0;
      last_acc = 1'b0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      t0 = cyc;
      fork
         begin
            for (int i = 0; i < navail; i++) begin
               int guard = 0;
               tx_data = pkt[i];
               tx_last = last_flag && (i == navail - 1);
               valid   = 1'b1;
               while (!r_s && guard < 400) begin
                  @(posedge clk); #1;
                  guard++;
               end
               chk("ready_wait", guard < 400, 1'b1);
               @(posedge clk); #1;
               if (i == 0) chk("accept_time_0", cyc, t0 + 1);
               if (i == 1 && chk_acc) chk("accept_time_1", cyc, t0 + 8 * cpb + 1);
               chk("ready_drop", r_s, 1'b0);
               if (tx_last) last_acc = 1'b1;
            end
            valid   = 1'b0;
            tx_last = 1'b0;
         end
         begin
            logic [1:0] e;
            while (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               for (int c = 0; c < cpb; c++) begin
                  @(posedge clk); #1;
                  chk("line", {dp_s, dm_s}, e);
                  chk("busy_high", b_s, 1'b1);
                  if (dn_s) done_cnt++;
                  if (e_s) err_cnt++;
                  if (last_acc) chk("ready_after_last", r_s, 1'b0);
               end
            end
            @(posedge clk); #1;
            chk("busy_fall", b_s, 1'b0);
            chk("done_pulse", dn_s, 1'b1);
            chk("idle_line", {dp_s, dm_s}, 2'b10);
            @(posedge clk); #1;
            chk("done_single", dn_s, 1'b0);
         end
      join
      chk("done_early", done_cnt, 0);
      chk("error_count", err_cnt, exp_err);
   endtask

   initial begin
      n_rst   = 1'b0;
      start   = 1'b0;
      sel     = 1'b0;
      tx_data = 8'h00;
      tx_last = 1'b0;
      valid   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dplus", dp1, 1'b1);
      chk("rst_dminus", dm1, 1'b0);
      chk("rst_ready", r1, 1'b0);
      chk("rst_busy", b1, 1'b0);
      chk("rst_done", dn1, 1'b0);
      chk("rst_error", e1, 1'b0);
      chk("rst_sweep_line", {dp2, dm2}, 2'b10);
      chk("rst_sweep_busy", b2, 1'b0);
      @(negedge clk) n_rst = 1'b1;

      // Single zero byte
      pkt[0] = 8'h00;
      run_pkt(1, 1'b1, 0, 1'b0);

      // All ones: stuff after six ones including SYNC's final 1
      pkt[0] = 8'hFF;
      run_pkt(1, 1'b1, 0, 1'b0);

      // Back-to-back bytes
      pkt[0] = 8'hA5;
      pkt[1] = 8'h3C;
      run_pkt(2, 1'b1, 0, 1'b1);

      // Start with no data: underrun right after SYNC
      run_pkt(0, 1'b0, 1, 1'b0);

      // Underrun after one non-last byte
      pkt[0] = 8'h00;
      run_pkt(1, 1'b0, 1, 1'b0);

      // Asynchronous reset in the middle of DATA
      tx_data = 8'hA5;
      tx_last = 1'b1;
      valid   = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 valid = 1'b0;
      tx_last = 1'b0;
      repeat (40) @(posedge clk);
      #2 n_rst = 1'b0;
      #1;
      chk("midrst_line", {dp1, dm1}, 2'b10);
      chk("midrst_ready", r1, 1'b0);
      chk("midrst_busy", b1, 1'b0);
      @(posedge clk); #1 n_rst = 1'b1;
      pkt[0] = 8'h00;
      run_pkt(1, 1'b1, 0, 1'b0);

      // Parameter sweep instance
      sel = 1'b1;
      pkt[0] = 8'hFF;
      run_pkt(1, 1'b1, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
